rast_tri_feeder: RTL and testbench



---
 rtl/rast_tri_feeder.sv | 161 ++++++++++++++++
 tb/tb_rast_tri_feeder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rast_tri_feeder.sv
// Triangle feeder for the rasterizer input: a DEPTH-entry FIFO followed by a single output slot that holds while rast halts.
// Optional back-face/degenerate culling on the FIFO head is enabled by defining RAST_FEEDER_CULL_EN.
module rast_tri_feeder #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri_S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          in_color_U,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic                                          halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
    output logic                                          validTri_R10H,
    output logic [31:0]                                   count_sent,
    output logic [31:0]                                   count_cull,
    output logic                                          idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Elaboration-time guards on the configuration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rast_tri_feeder: DEPTH must be a power of two >= 2");
    end
    if ((RADIX < 0) || (RADIX > SIGFIG)) begin : g_bad_radix
        $error("rast_tri_feeder: RADIX must lie within 0..SIGFIG");
    end
    if ((VERTS < 3) || (AXIS < 2)) begin : g_bad_shape
        $error("rast_tri_feeder: need at least 3 vertices with x and y");
    end

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_mem   [DEPTH];
    logic [COLORS-1:0][SIGFIG-1:0]          color_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] slot_tri_q, slot_tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          slot_col_q, slot_col_d;
    logic [31:0]   sent_q, sent_d;

    logic push, pop, handoff, cull_head;

    // Ready looks only at registered occupancy, so a full FIFO never passes through.
    assign in_ready = rst && (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign handoff  = valid_q && halt_RnnnnL;
    assign pop      = (!valid_q || handoff) && (count_q != '0);

`ifdef RAST_FEEDER_CULL_EN
    logic [SIGFIG-1:0]   x0, y0, x1, y1, x2, y2;
    logic [SIGFIG:0]     dx1, dy1, dx2, dy2;
    logic [2*SIGFIG+1:0] prod_a, prod_b;
    logic [2*SIGFIG+2:0] area2;
    logic [31:0]         cull_q, cull_d;

    // Two's-complement arithmetic on explicitly sign-extended operands; widths grow so nothing truncates.
    always_comb begin
        x0     = tri_mem[rd_ptr_q][0][0];
        y0     = tri_mem[rd_ptr_q][0][1];
        x1     = tri_mem[rd_ptr_q][1][0];
        y1     = tri_mem[rd_ptr_q][1][1];
        x2     = tri_mem[rd_ptr_q][2][0];
        y2     = tri_mem[rd_ptr_q][2][1];
        dx1    = {x1[SIGFIG-1], x1} - {x0[SIGFIG-1], x0};
        dy1    = {y1[SIGFIG-1], y1} - {y0[SIGFIG-1], y0};
        dx2    = {x2[SIGFIG-1], x2} - {x0[SIGFIG-1], x0};
        dy2    = {y2[SIGFIG-1], y2} - {y0[SIGFIG-1], y0};
        prod_a = {{(SIGFIG+1){dx1[SIGFIG]}}, dx1} * {{(SIGFIG+1){dy2[SIGFIG]}}, dy2};
        prod_b = {{(SIGFIG+1){dx2[SIGFIG]}}, dx2} * {{(SIGFIG+1){dy1[SIGFIG]}}, dy1};
        area2  = {prod_a[2*SIGFIG+1], prod_a} - {prod_b[2*SIGFIG+1], prod_b};
        // Counter-clockwise is front-facing; zero area is degenerate.
        cull_head = area2[2*SIGFIG+2] || (area2 == '0);
        cull_d    = cull_q + ((pop && cull_head) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cull_q <= '0;
        end else begin
            cull_q <= cull_d;
        end
    end

    assign count_cull = cull_q;
`else
    assign cull_head  = 1'b0;
    assign count_cull = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        valid_d    = valid_q;
        slot_tri_d = slot_tri_q;
        slot_col_d = slot_col_q;
        sent_d     = sent_q + (handoff ? 32'd1 : 32'd0);
        count_d    = count_q + CW'(push) - CW'(pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            valid_d  = !cull_head;
            if (!cull_head) begin
                slot_tri_d = tri_mem[rd_ptr_q];
                slot_col_d = color_mem[rd_ptr_q];
            end
        end else if (handoff) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            slot_tri_q <= '0;
            slot_col_q <= '0;
            sent_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            slot_tri_q <= slot_tri_d;
            slot_col_q <= slot_col_d;
            sent_q     <= sent_d;
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            tri_mem[wr_ptr_q]   <= in_tri_S;
            color_mem[wr_ptr_q] <= in_color_U;
        end
    end

    assign tri_R10S      = slot_tri_q;
    assign color_R10U    = slot_col_q;
    assign validTri_R10H = valid_q;
    assign count_sent    = sent_q;
    assign idle          = (count_q == '0) && !valid_q;

endmodule

// File: tb/tb_rast_tri_feeder.sv
// Scoreboard bench for rast_tri_feeder: accepted triangles are queued, and each handoff to rast is compared in order.
module tb_rast_tri_feeder;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int DEPTH  = 4;

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]                 col_t;
    typedef struct { tri_t t; col_t c; } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    tri_t        in_tri_S = '0;
    col_t        in_color_U = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        halt_RnnnnL = 1'b1;
    tri_t        tri_R10S;
    col_t        color_R10U;
    logic        validTri_R10H;
    logic [31:0] count_sent;
    logic [31:0] count_cull;
    logic        idle;

    int    errors = 0;
    int    checks = 0;
    int    exp_sent = 0;
    int    exp_cull = 0;
    item_t sb[$];

    bit    hold_prev = 0;
    tri_t  held_tri;
    col_t  held_col;

    rast_tri_feeder #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS),
        .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_tri_S(in_tri_S), .in_color_U(in_color_U),
        .in_valid(in_valid), .in_ready(in_ready),
        .halt_RnnnnL(halt_RnnnnL),
        .tri_R10S(tri_R10S), .color_R10U(color_R10U),
        .validTri_R10H(validTri_R10H),
        .count_sent(count_sent), .count_cull(count_cull),
        .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic tri_t mk_tri(input int x0, input int y0, input int x1,
                                    input int y1, input int x2, input int y2);
        tri_t t;
        t = '0;
        t[0][0] = SIGFIG'(x0); t[0][1] = SIGFIG'(y0);
        t[1][0] = SIGFIG'(x1); t[1][1] = SIGFIG'(y1);
        t[2][0] = SIGFIG'(x2); t[2][1] = SIGFIG'(y2);
        for (int v = 0; v < VERTS; v++)
            for (int a = 2; a < AXIS; a++)
                t[v][a] = SIGFIG'(100 + 10 * v + x0);
        return t;
    endfunction

    function automatic col_t rnd_col();
        col_t c;
        logic [31:0] r;
        for (int i = 0; i < COLORS; i++) begin
            r = $urandom;
            c[i] = r[SIGFIG-1:0];
        end
        return c;
    endfunction

    function automatic longint area2(input tri_t t);
        longint x0, y0, x1, y1, x2, y2;
        x0 = longint'($signed(t[0][0])); y0 = longint'($signed(t[0][1]));
        x1 = longint'($signed(t[1][0])); y1 = longint'($signed(t[1][1]));
        x2 = longint'($signed(t[2][0])); y2 = longint'($signed(t[2][1]));
        return (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
    endfunction

    function automatic bit model_culls(input tri_t t);
`ifdef RAST_FEEDER_CULL_EN
        return area2(t) <= 0;
`else
        return (area2(t) != area2(t));
`endif
    endfunction

    // Outputs and inputs are stable at the falling edge; decide what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (validTri_R10H !== 1'b1 || tri_R10S !== held_tri || color_R10U !== held_col) begin
                    errors++;
                    $display("FAIL hold: valid=%b tri=%h col=%h, required valid=1 tri=%h col=%h",
                             validTri_R10H, tri_R10S, color_R10U, held_tri, held_col);
                end
            end
            hold_prev = validTri_R10H && !halt_RnnnnL;
            held_tri  = tri_R10S;
            held_col  = color_R10U;

            if (validTri_R10H && halt_RnnnnL) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL handoff_unexpected: tri=%h presented, required no triangle", tri_R10S);
                end else begin
                    item_t e;
                    e = sb.pop_front();
                    if (tri_R10S !== e.t || color_R10U !== e.c) begin
                        errors++;
                        $display("FAIL handoff_data: tri=%h col=%h, required tri=%h col=%h",
                                 tri_R10S, color_R10U, e.t, e.c);
                    end
                end
            end

            if (in_valid && in_ready && !model_culls(in_tri_S)) begin
                item_t n;
                n.t = in_tri_S;
                n.c = in_color_U;
                sb.push_back(n);
            end
        end
    end

    task automatic push_tri(input tri_t t, input col_t c);
        bit done;
        int n;
        done = 0;
        n = 0;
        in_tri_S = t;
        in_color_U = c;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                errors++;
                checks++;
                $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(idle && sb.size() == 0) && n <= 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(idle && sb.size() == 0)) begin
            errors++;
            $display("FAIL %s_drain: idle=%b pending=%0d, required idle=1 pending=0", name, idle, sb.size());
        end
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (count_sent !== 32'(exp_sent) || count_cull !== 32'(exp_cull)) begin
            errors++;
            $display("FAIL %s_counts: sent=%0d cull=%0d, required sent=%0d cull=%0d",
                     name, count_sent, count_cull, exp_sent, exp_cull);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (validTri_R10H !== 1'b0 || in_ready !== 1'b0 || idle !== 1'b1 || tri_R10S !== '0 || color_R10U !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b idle=%b tri=%h, required 0 0 1 0",
                     validTri_R10H, in_ready, idle, tri_R10S);
        end
        check_counts("reset");
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b idle=%b, required 1 1", in_ready, idle);
        end
    endtask

    task automatic test_single();
        tri_t t;
        t = mk_tri(0, 0, 4, 0, 0, 4);
        halt_RnnnnL = 1'b1;
        push_tri(t, rnd_col());
        checks++;
        if (validTri_R10H !== 1'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL single_edge_k: valid=%b idle=%b, required 0 0", validTri_R10H, idle);
        end
        @(posedge clk);
        #1;
        checks++;
        if (validTri_R10H !== 1'b1 || tri_R10S !== t) begin
            errors++;
            $display("FAIL single_edge_k1: valid=%b tri=%h, required 1 %h", validTri_R10H, tri_R10S, t);
        end
        @(posedge clk);
        #1;
        checks++;
        if (validTri_R10H !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_edge_k2: valid=%b idle=%b, required 0 1", validTri_R10H, idle);
        end
        exp_sent += 1;
        check_counts("single");
    endtask

    task automatic test_back_to_back();
        tri_t first;
        int n;
        halt_RnnnnL = 1'b0;
        first = mk_tri(10, 10, 14, 10, 10, 14);
        push_tri(first, rnd_col());
        for (int i = 1; i <= DEPTH; i++)
            push_tri(mk_tri(10 + i, 10 + i, 14 + i, 10 + i, 10 + i, 14 + i), rnd_col());
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_ready: in_ready=%b, required 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (validTri_R10H !== 1'b1 || tri_R10S !== first || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frozen: valid=%b tri=%h ready=%b, required 1 %h 0",
                     validTri_R10H, tri_R10S, in_ready, first);
        end
        halt_RnnnnL = 1'b1;
        n = 0;
        while (!idle && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != DEPTH + 1) begin
            errors++;
            $display("FAIL b2b_rate: drained in %0d cycles, required %0d", n, DEPTH + 1);
        end
        drain("b2b");
        exp_sent += DEPTH + 1;
        check_counts("b2b");
    endtask

    task automatic test_halt_toggle();
        bit run;
        run = 1;
        halt_RnnnnL = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push_tri(mk_tri(-20 + i, 5, -16 + i, 5, -20 + i, 9 + i), rnd_col());
                run = 0;
            end
            begin
                while (run) begin
                    @(posedge clk);
                    #1;
                    halt_RnnnnL = ~halt_RnnnnL;
                end
            end
        join
        halt_RnnnnL = 1'b1;
        drain("toggle");
        exp_sent += 10;
        check_counts("toggle");
    endtask

    task automatic test_cull();
        halt_RnnnnL = 1'b1;
        push_tri(mk_tri(0, 0, 4, 0, 0, 4), rnd_col());
        push_tri(mk_tri(0, 0, 0, 4, 4, 0), rnd_col());
        push_tri(mk_tri(0, 0, 1, 1, 2, 2), rnd_col());
        drain("cull");
`ifdef RAST_FEEDER_CULL_EN
        exp_sent += 1;
        exp_cull += 2;
`else
        exp_sent += 3;
`endif
        check_counts("cull");
    endtask

    task automatic test_full_simul();
        tri_t extra;
        halt_RnnnnL = 1'b0;
        for (int i = 0; i <= DEPTH; i++)
            push_tri(mk_tri(30 + i, 2, 38 + i, 2, 30 + i, 9), rnd_col());
        extra = mk_tri(50, 50, 57, 50, 50, 57);
        in_tri_S = extra;
        in_color_U = rnd_col();
        in_valid = 1'b1;
        halt_RnnnnL = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_blocked: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_reopen: in_ready=%b, required 1", in_ready);
        end
        halt_RnnnnL = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_accepted: in_ready=%b, required 0 (FIFO full again)", in_ready);
        end
        halt_RnnnnL = 1'b1;
        drain("simul");
        exp_sent += DEPTH + 2;
        check_counts("simul");
    endtask

    task automatic test_reset_mid();
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 4; i++)
            push_tri(mk_tri(60 + i, 1, 66 + i, 1, 60 + i, 7), rnd_col());
        #2 rst = 1'b0;
        #1;
        sb.delete();
        exp_sent = 0;
        exp_cull = 0;
        checks++;
        if (validTri_R10H !== 1'b0 || in_ready !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL midreset_immediate: valid=%b ready=%b idle=%b, required 0 0 1",
                     validTri_R10H, in_ready, idle);
        end
        check_counts("midreset");
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (idle !== 1'b1 || validTri_R10H !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release: idle=%b valid=%b ready=%b, required 1 0 1",
                     idle, validTri_R10H, in_ready);
        end
        check_counts("midreset_release");
        halt_RnnnnL = 1'b1;
        push_tri(mk_tri(3, 3, 9, 3, 3, 9), rnd_col());
        drain("midreset_after");
        exp_sent = 1;
        check_counts("midreset_after");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_halt_toggle();
        test_cull();
        test_full_simul();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
